// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-service engine.
package cache_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned TAG_W           = 19;
  localparam int unsigned SET_W           = 7;
  localparam int unsigned WORD_OFF_W      = 4;
  localparam int unsigned WORDS_PER_BLOCK = 16;
  localparam int unsigned WORD_BITS       = 32;
  localparam int unsigned BLOCK_BITS      = 512;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WB    = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;
  localparam logic [1:0] ST_ALLOC = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    WB    = ST_WB,
    FILL  = ST_FILL,
    ALLOC = ST_ALLOC
  } miss_state_e;

  // Word-aligned memory address of one beat within a block.
  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [TAG_W-1:0]      tag,
    input logic [SET_W-1:0]      set,
    input logic [WORD_OFF_W-1:0] beat
  );
    return {tag, set, beat, 2'b00};
  endfunction

endpackage

// File: rtl/cache_miss_handler_if.sv
// Word-serial memory bus between the miss handler (master) and main memory (slave).
interface cache_miss_handler_if;

  logic                        mem_req;
  logic                        mem_we;
  logic [cache_pkg::ADDR_W-1:0]    mem_addr;
  logic [cache_pkg::WORD_BITS-1:0] mem_wdata;
  logic                        mem_ack;
  logic [cache_pkg::WORD_BITS-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/cache_miss_handler_beat_counter.sv
// Beat index within a block transfer; advances on each acknowledged beat.
module miss_beat_counter
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  advance,
  output logic [WORD_OFF_W-1:0] beat,
  output logic                  last
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      beat <= '0;
    end else if (advance) begin
      beat <= beat + 1'b1;
    end
  end

  assign last = (beat == '1);

endmodule

// File: rtl/cache_miss_handler.sv
// Miss-service engine: optional dirty-victim writeback, block fill, then a one-cycle allocate.
module cache_miss_handler
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_W-1:0]     miss_addr,
  input  logic                  evict_dirty,
  input  logic [TAG_W-1:0]      evict_tag,
  input  logic [SET_W-1:0]      evict_set,
  input  logic [BLOCK_BITS-1:0] evict_data_block,
  output logic                  busy,
  output logic                  done,
  output logic                  alloc_enable,
  output logic [ADDR_W-1:0]     alloc_addr,
  output logic [BLOCK_BITS-1:0] alloc_data_block,
  cache_miss_handler_if.master  mem
);

  miss_state_e               state;
  logic [TAG_W+SET_W-1:0]    blk_q;
  logic [TAG_W-1:0]          victim_tag_q;
  logic [SET_W-1:0]          victim_set_q;
  logic [BLOCK_BITS-1:0]     victim_q;
  logic [BLOCK_BITS-1:0]     fill_q;
  logic [WORD_OFF_W-1:0]     beat;
  logic                      last_beat;
  logic                      accept;
  logic                      beat_ack;
  logic [8:0]                word_lsb;
  logic                      unused_offset;

  // Byte offset within the block never reaches memory or the array.
  assign unused_offset = ^miss_addr[5:0];

  assign accept   = (state == IDLE) && miss_req;
  assign beat_ack = ((state == WB) || (state == FILL)) && mem.mem_ack;
  assign word_lsb = {beat, 5'b0};

  miss_beat_counter u_beat (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .advance (beat_ack),
    .beat    (beat),
    .last    (last_beat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      blk_q        <= '0;
      victim_tag_q <= '0;
      victim_set_q <= '0;
      victim_q     <= '0;
      fill_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            blk_q        <= miss_addr[31:6];
            victim_tag_q <= evict_tag;
            victim_set_q <= evict_set;
            victim_q     <= evict_data_block;
            state        <= evict_dirty ? WB : FILL;
          end
        end
        WB: begin
          if (beat_ack && last_beat) state <= FILL;
        end
        FILL: begin
          if (beat_ack) begin
            fill_q[word_lsb +: WORD_BITS] <= mem.mem_rdata;
            if (last_beat) state <= ALLOC;
          end
        end
        ALLOC: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    done          = (state == ALLOC);
    alloc_enable  = (state == ALLOC);
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      WB: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = beat_addr(victim_tag_q, victim_set_q, beat);
        mem.mem_wdata = victim_q[word_lsb +: WORD_BITS];
      end
      FILL: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = beat_addr(blk_q[TAG_W+SET_W-1:SET_W], blk_q[SET_W-1:0], beat);
      end
      default: ;
    endcase
  end

  assign alloc_addr       = {blk_q, 6'b0};
  assign alloc_data_block = fill_q;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler: clean/dirty misses, wait states, ignored requests, mid-fill reset.
module tb_cache_miss_handler;
  import cache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  miss_req;
  logic [31:0]           miss_addr;
  logic                  evict_dirty;
  logic [TAG_W-1:0]      evict_tag;
  logic [SET_W-1:0]      evict_set;
  logic [511:0]          evict_data_block;
  logic                  busy;
  logic                  done;
  logic                  alloc_enable;
  logic [31:0]           alloc_addr;
  logic [511:0]          alloc_data_block;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned last_alloc_cyc = 0;
  int unsigned alloc_count = 0;

  logic [511:0] vic_a;
  logic [511:0] vic_b;
  int unsigned  a_before;

  cache_miss_handler_if mif();

  cache_miss_handler dut (
    .clk              (clk),
    .rst              (rst),
    .miss_req         (miss_req),
    .miss_addr        (miss_addr),
    .evict_dirty      (evict_dirty),
    .evict_tag        (evict_tag),
    .evict_set        (evict_set),
    .evict_data_block (evict_data_block),
    .busy             (busy),
    .done             (done),
    .alloc_enable     (alloc_enable),
    .alloc_addr       (alloc_addr),
    .alloc_data_block (alloc_data_block),
    .mem              (mif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alloc_enable) begin
      alloc_count    <= alloc_count + 1;
      last_alloc_cyc <= cyc + 1;
    end
  end

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_busy"}, busy, 1'b0);
    check_val({tag, "_alloc"}, alloc_enable, 1'b0);
    check_val({tag, "_done"}, done, 1'b0);
    check_val({tag, "_mem_req"}, mif.mem_req, 1'b0);
    check_val({tag, "_mem_we"}, mif.mem_we, 1'b0);
    check_val({tag, "_mem_addr"}, mif.mem_addr, 32'h0);
    check_val({tag, "_mem_wdata"}, mif.mem_wdata, 32'h0);
  endtask

  task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [TAG_W-1:0] tag,
                          input logic [SET_W-1:0] set, input logic [511:0] vic,
                          input int unsigned ack_pct, input logic [31:0] rbase, input bit poke);
    int unsigned nbeats, waits, run_len, k, a0, t_req, i;
    bit          wr, ack, poked;
    logic [31:0]  exp_addr;
    logic [511:0] exp_blk;
    nbeats = dirty ? 32 : 16;
    waits = 0; run_len = 0; poked = 0; i = 0; exp_blk = '0;
    a0 = alloc_count;
    miss_addr = addr; evict_dirty = dirty; evict_tag = tag; evict_set = set;
    evict_data_block = vic; miss_req = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
    t_req = cyc;
    while (i < nbeats) begin
      wr = dirty && (i < 16);
      k  = (dirty && !wr) ? i - 16 : i;
      exp_addr = wr ? {tag, set, 4'(k), 2'b00} : {addr[31:6], 4'(k), 2'b00};
      check_val("mem_req", mif.mem_req, 1'b1);
      check_val("mem_we", mif.mem_we, wr);
      if (wr) begin
        check_val("wb_addr", mif.mem_addr, exp_addr);
        check_val("wb_data", mif.mem_wdata, vic[k*32 +: 32]);
      end else begin
        check_val("fill_addr", mif.mem_addr, exp_addr);
      end
      check_val("busy_xfer", busy, 1'b1);
      check_val("alloc_early", alloc_enable, 1'b0);
      ack = ($urandom_range(0, 99) < ack_pct) || (run_len >= 20);
      miss_req = 1'b0;
      if (poke && !wr && k == 3 && !poked) begin
        miss_req = 1'b1; miss_addr = 32'h5555_0000; evict_dirty = 1'b1; poked = 1;
      end
      mif.mem_ack   = ack;
      mif.mem_rdata = ack ? rbase + k : 32'hDEAD_BEEF;
      if (ack && !wr) exp_blk[k*32 +: 32] = rbase + k;
      @(posedge clk); #1;
      if (ack) begin i++; run_len = 0; end
      else begin waits++; run_len++; end
    end
    mif.mem_ack = 1'b0;
    miss_req = 1'b0;
    check_val("alloc_enable", alloc_enable, 1'b1);
    check_val("done", done, 1'b1);
    check_val("busy_alloc", busy, 1'b1);
    check_val("mem_req_alloc", mif.mem_req, 1'b0);
    check_val("alloc_addr", alloc_addr, {addr[31:6], 6'b0});
    check_val("alloc_data", alloc_data_block, exp_blk);
    if (poke) begin
      miss_req = 1'b1; miss_addr = 32'h6666_0040; evict_dirty = 1'b1;
    end
    @(posedge clk); #1;
    miss_req = 1'b0;
    check_val("alloc_once", alloc_enable, 1'b0);
    check_val("idle_after", busy, 1'b0);
    check_val("mem_req_idle", mif.mem_req, 1'b0);
    check_val("alloc_count", alloc_count - a0, 1);
    check_val("latency", last_alloc_cyc - t_req, (dirty ? 33 : 17) + waits);
    check_val("alloc_addr_hold", alloc_addr, {addr[31:6], 6'b0});
    check_val("alloc_data_hold", alloc_data_block, exp_blk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; evict_dirty = 1'b0;
    evict_tag = '0; evict_set = '0; evict_data_block = '0;
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;
    for (int k = 0; k < 16; k++) begin
      vic_a[k*32 +: 32] = 32'hD0 + k;
      vic_b[k*32 +: 32] = 32'h5A5A_0000 + k;
    end

    repeat (3) @(posedge clk);
    #1;
    check_quiet("rst");
    check_val("rst_alloc_addr", alloc_addr, 32'h0);
    check_val("rst_alloc_data", alloc_data_block, 512'h0);
    rst = 1'b0;

    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(posedge clk); #1;
      check_quiet("idle_ack");
      check_val("idle_ack_alloc_data", alloc_data_block, 512'h0);
    end
    mif.mem_ack = 1'b0;

    run_miss(32'h0000_1240, 1'b0, '0, '0, '0, 100, 32'hA000_0000, 0);
    run_miss(32'h0000_8040, 1'b1, 19'h12345, 7'h09, vic_a, 100, 32'hB000_0000, 0);
    run_miss(32'h7FFF_FFC4, 1'b1, 19'h12345, 7'h09, vic_a, 30, 32'hC000_0000, 0);
    run_miss(32'h0001_0080, 1'b0, '0, '0, '0, 100, 32'hE000_0000, 1);
    run_miss(32'h0002_0100, 1'b1, 19'h70F0F, 7'h55, vic_b, 100, 32'h9000_0000, 0);

    a_before = alloc_count;
    miss_addr = 32'h0000_3000; evict_dirty = 1'b0; miss_req = 1'b1;
    @(posedge clk); #1;
    miss_req = 1'b0;
    for (int j = 0; j < 7; j++) begin
      mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1111_0000 + j;
      @(posedge clk); #1;
    end
    mif.mem_ack = 1'b0;
    check_val("fill_beat7_addr", mif.mem_addr, 32'h0000_301C);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_quiet("mid_rst");
    check_val("mid_rst_alloc_data", alloc_data_block, 512'h0);
    repeat (2) @(posedge clk);
    #1;
    check_val("no_alloc_after_rst", alloc_count - a_before, 0);
    check_quiet("post_rst");

    run_miss(32'h0000_3000, 1'b0, '0, '0, '0, 100, 32'hF000_0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Miss-service engine sitting between the 4-way, 128-set, 64-byte-block cache array and word-serial main memory. On a miss it captures the array's victim information, writes the victim block back to memory if dirty (16 word beats), fetches the missing block (16 word beats), then drives the array's allocation port for one cycle. It owns all memory traffic for the cache; the array never talks to memory directly.

## Interface
- TAG_W, 19, tag width (addr[31:13])
- SET_W, 7, set index width (addr[12:6])
- WORDS, 16, 32-bit words per block (offset addr[5:2])
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- miss_req  in  1  one-cycle pulse: array reported a miss; all miss/evict inputs valid this cycle
- miss_addr  in  32  CPU address that missed
- evict_dirty  in  1  victim way is valid and dirty
- evict_tag  in  TAG_W  victim tag
- evict_set  in  SET_W  victim set
- evict_data_block  in  512  victim data, word k at bits [k*32+:32]
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse, coincident with alloc_enable
- alloc_enable  out  1  one-cycle allocate strobe to array
- alloc_addr  out  32  {miss_addr[31:6], 6'b0}
- alloc_data_block  out  512  fetched block, word k at bits [k*32+:32]
- mem_req  out  1  memory beat request
- mem_we  out  1  1 = write beat, 0 = read beat
- mem_addr  out  32  word-aligned beat address
- mem_wdata  out  32  write data for current beat
- mem_ack  in  1  beat completes on cycle where mem_req && mem_ack
- mem_rdata  in  32  read data, valid on cycle of mem_ack for read beats

## Operation
- States: IDLE, WB, FILL, ALLOC.
- IDLE: miss_req=1 -> latch miss_addr, evict_*; beat=0; go WB if evict_dirty else FILL. miss_req while busy is ignored (upstream contract: never issued).
- WB: mem_req=1, mem_we=1, mem_addr={evict_tag, evict_set, beat, 2'b00}, mem_wdata=latched word[beat]. On ack: beat==15 -> beat=0, go FILL; else beat+1.
- FILL: mem_req=1, mem_we=0, mem_addr={miss_addr[31:6], beat, 2'b00}. On ack: buffer word[beat]=mem_rdata; beat==15 -> go ALLOC; else beat+1.
- ALLOC: alloc_enable=1, done=1 for exactly one cycle, then IDLE. Way selection is the array's job.
- Words transferred in ascending order 0..15; no critical-word-first.
- mem_ack while mem_req=0 ignored. mem_ack held low: state, beat, all mem_* outputs held stable indefinitely.
- Beat counter is 4 bits, wraps 15->0 only on state exit.

## Timing
- Reset values: busy, done, alloc_enable, mem_req, mem_we = 0; mem_addr, mem_wdata, alloc_addr = 0; alloc_data_block = 0; state IDLE, beat 0.
- Reset mid-transaction: next edge returns to IDLE, mem_req drops, no alloc issued, partial buffer discarded.
- miss_req at edge T -> mem_req high from T+1.
- Zero-wait memory (ack every cycle): clean miss alloc_enable at T+17; dirty miss at T+33.
- Each wait cycle (req && !ack) adds exactly one cycle.
- Back-to-back: a new miss_req is accepted the cycle after ALLOC (first IDLE cycle).
- alloc_addr/alloc_data_block held stable from ALLOC until next accepted miss.

## Structure
- Shared package cache_pkg: TAG_W, SET_W, WORD_OFF_W=4, WORDS_PER_BLOCK, BLOCK_BITS=512, state enum, helper function composing block/beat address from tag, set, beat.
- One sub-module: miss_beat_counter (4-bit counter with clear, advance-on-ack, last-beat flag); FSM and data buffers stay in top.

## Test plan
- Clean miss, miss_addr=0x0000_1240, zero-wait memory returning rdata=0xA000_0000+beat -> 16 reads at 0x1240..0x127C, alloc_enable at T+17, alloc_addr=0x1240, word k=0xA000_000k.
- Dirty miss, evict_tag=0x12345, evict_set=0x09, data word k=0xD0+k -> 16 writes at 0x2468_A240..0x2468_A27C with wdata 0xD0+k, then 16 reads, alloc at T+33.
- Random wait states (ack probability 30%) on dirty miss -> mem_addr/wdata stable while unacked, order preserved, latency = 33 + wait cycles.
- miss_req pulsed during FILL and during ALLOC -> ignored; exactly one alloc; second miss_req one cycle after done accepted.
- rst asserted at FILL beat 7 -> next cycle busy=0, mem_req=0, no alloc_enable; fresh miss then completes correctly.
- mem_ack asserted while idle -> no state change, all outputs remain reset values.
